glb_block_framer: RTL and testbench
===================================

Name: glb_block_framer

Overview:
- Synthesizable producer stage that sits directly upstream of the GLB read-side consumer.
- Collects a raw word stream, delimited by in_last, into an internal buffer.
- Re-emits each block as a length-prefixed frame on a valid/ready port: one header word holding the data-word count, then the data words in arrival order.
- Asserts done once NUM_BLOCKS frames have been fully transmitted.

Parameters:
- DATA_WIDTH, 16, width of the data and header words.
- DEPTH, 256, maximum data words per block; power of 2; must satisfy DEPTH <= 2^DATA_WIDTH - 1.
- NUM_BLOCKS, 2, number of frames before done asserts; 0 = unlimited, done never asserts.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  DATA_WIDTH  input data word
- in_valid  in  1  input word valid
- in_last  in  1  qualifies in_data as the final word of its block
- in_ready  out  1  framer accepts an input word
- out_data  out  DATA_WIDTH  header or data word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts a word
- trunc  out  1  one-cycle pulse: block force-closed at DEPTH words
- done  out  1  sticky: NUM_BLOCKS frames sent

Behaviour:
- Reset: rst_n sampled low at a posedge clears everything, including mid-frame. Buffer contents and word/block counters are discarded. Outputs: in_ready=0, out_valid=0, out_data=0, trunc=0, done=0. The first cycle after reset is FILL.
- Transfers: an input word transfers on a posedge with in_valid && in_ready. An output word transfers on a posedge with out_valid && out_ready.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold stable. out_valid never depends combinationally on out_ready.
- States:
  - FILL: in_ready=1, out_valid=0. Each accepted word is written to buf[cnt] and cnt increments.
    - Accepted word with in_last=1 -> HDR.
    - Accepted word that makes cnt==DEPTH with in_last=0 -> HDR and trunc=1 for exactly one cycle (the following cycle). The next input word starts a new block.
  - HDR: in_ready=0, out_valid=1, out_data=cnt zero-extended to DATA_WIDTH. On transfer, rd_ptr=0 -> DRAIN.
  - DRAIN: in_ready=0, out_valid=1, out_data=buf[rd_ptr].
    - Transfer with rd_ptr<cnt-1: rd_ptr increments.
    - Transfer with rd_ptr==cnt-1: blk_cnt increments, cnt clears.
    - Next state: DONE if NUM_BLOCKS!=0 and blk_cnt+1==NUM_BLOCKS; otherwise FILL.
  - DONE: in_ready=0, out_valid=0, done=1 until reset.
- Latency: the last input word is accepted at edge N. The header is valid in cycle N+1 (registered). Data words follow at one per cycle under continuous out_ready. Frame length = cnt+1 cycles minimum.
- No zero-length blocks: in_last qualifies a data word, so cnt >= 1 always.
- Single buffer: input stalls for the full HDR/DRAIN duration. in_last while in_valid=0 is ignored.
- Counters: cnt is clog2(DEPTH)+1 bits. blk_cnt saturates at NUM_BLOCKS and does not wrap.

Optional Feature:
- Macro: GLB_FRAMER_CHECKSUM_EN.
- With the macro defined:
  - A running DATA_WIDTH-bit wrap-around sum of the block's data words is kept, cleared at block start.
  - After the last DRAIN word, a CKSUM state presents the sum with out_valid=1, following the same handshake rules.
  - Block completion and the transition to FILL/DONE occur on the CKSUM transfer.
  - The header still counts data words only.
- Without the macro: no CKSUM state and no sum register. Frame = header + data only.

Test Plan:
- Reset, then words 0x0011,0x0022,0x0033 (last on 0x0033), out_ready=1 -> out sequence 0x0003,0x0011,0x0022,0x0033. Header valid the cycle after 0x0033 is accepted. in_ready=0 throughout output.
- NUM_BLOCKS=2: blocks of 1 word (0xAAAA) then 2 words (0x1,0x2) -> 0x0001,0xAAAA,0x0002,0x0001,0x0002. done rises the cycle after the final transfer and stays 1. in_ready stays 0 afterwards.
- DEPTH=4: 6 words 0..5, last on 5 -> trunc pulses once; frames 0x0004,0,1,2,3 then 0x0002,4,5.
- Backpressure: toggle out_ready 1,0,0,1 during DRAIN -> out_data/out_valid unchanged while stalled; no word lost or duplicated.
- Reset asserted mid-DRAIN for 1 cycle -> next cycle out_valid=0, in_ready=1. A fresh 1-word block 0x0F0F yields 0x0001,0x0F0F. blk_cnt restarts from 0.
- GLB_FRAMER_CHECKSUM_EN: block 0xFFFF,0x0002 -> 0x0002,0xFFFF,0x0002,0x0001.

Source files
------------

// File: rtl/glb_block_framer.sv
// -----------------------------------------------------------------------------
// glb_block_framer
//
// Producer stage feeding the GLB read-side consumer. Raw words arriving on the
// input port are collected into a single internal buffer until in_last (or
// until the buffer holds DEPTH words). The block is then re-emitted on the
// output port as a length-prefixed frame:
//   header word (data-word count, zero-extended), then the data words in order.
// Once NUM_BLOCKS frames have been sent, done rises and stays high until
// reset. NUM_BLOCKS = 0 means unlimited; done never rises.
//
// Optional feature (macro GLB_FRAMER_CHECKSUM_EN):
//   A DATA_WIDTH-bit wrap-around sum of the block's data words is appended
//   after the last data word as an extra frame word. The header still counts
//   data words only.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (clears state, counters, outputs)
//   in_data    input data word
//   in_valid   input word valid
//   in_last    final word of the current block (ignored while in_valid=0)
//   in_ready   framer accepts an input word (high only while filling)
//   out_data   header, data or checksum word (registered)
//   out_valid  out_data valid (registered, independent of out_ready)
//   out_ready  downstream accepts a word
//   trunc      one-cycle pulse: block force-closed at DEPTH words
//   done       sticky: NUM_BLOCKS frames fully transmitted
// -----------------------------------------------------------------------------

module glb_block_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int NUM_BLOCKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  trunc,
    output logic                  done
);

    // Buffer address width, word counter width (must hold DEPTH itself) and
    // block counter width (must hold NUM_BLOCKS itself, since it saturates).
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BLK_W = (NUM_BLOCKS > 0) ? $clog2(NUM_BLOCKS + 1) : 1;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DRAIN = 3'd2,
`ifdef GLB_FRAMER_CHECKSUM_EN
        ST_CKSUM = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_e;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_e                  state_q,     state_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic [PTR_W-1:0]        rd_ptr_q,    rd_ptr_d;
    logic [BLK_W-1:0]        blk_cnt_q,   blk_cnt_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                    trunc_q,     trunc_d;
    logic                    done_q,      done_d;
`ifdef GLB_FRAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum_q,       sum_d;
`endif

    // Block buffer
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Handshake and control helpers
    logic                    in_fire;
    logic                    out_fire;
    logic                    wr_en;
    logic                    rd_last;
    logic                    last_blk;
    logic                    blk_end;
    logic [PTR_W-1:0]        rd_inc;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // The data word being presented is the final one of the block.
    assign rd_last  = (CNT_W'(rd_ptr_q) == (cnt_q - CNT_W'(1)));
    assign rd_inc   = rd_ptr_q + PTR_W'(1);

    // The block now completing is the one that reaches NUM_BLOCKS.
    assign last_blk = (NUM_BLOCKS != 0) && ((int'(blk_cnt_q) + 1) == NUM_BLOCKS);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // leaves it unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        blk_cnt_d   = blk_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        trunc_d     = 1'b0;
        done_d      = done_q;
        wr_en       = 1'b0;
        blk_end     = 1'b0;
`ifdef GLB_FRAMER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            ST_FILL: begin
                // in_ready is low for the first cycle after reset and rises
                // here; it drops on the edge that closes the block.
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_fire) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef GLB_FRAMER_CHECKSUM_EN
                    // The first word of a block restarts the running sum.
                    sum_d = ((cnt_q == '0) ? '0 : sum_q) + in_data;
`endif
                    if (in_last || (cnt_d == CNT_W'(DEPTH))) begin
                        state_d     = ST_HDR;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_data_d  = DATA_WIDTH'(cnt_d);
                        // A block closed by the size limit rather than by
                        // in_last is flagged for one cycle.
                        trunc_d     = !in_last;
                    end
                end
            end

            ST_HDR: begin
                if (out_fire) begin
                    // out_data is registered, so the first data word is
                    // fetched on the header transfer.
                    state_d    = ST_DRAIN;
                    rd_ptr_d   = '0;
                    out_data_d = mem_q[PTR_W'(0)];
                end
            end

            ST_DRAIN: begin
                if (out_fire) begin
                    if (!rd_last) begin
                        rd_ptr_d   = rd_inc;
                        out_data_d = mem_q[rd_inc];
                    end else begin
`ifdef GLB_FRAMER_CHECKSUM_EN
                        state_d    = ST_CKSUM;
                        out_data_d = sum_q;
`else
                        blk_end    = 1'b1;
`endif
                    end
                end
            end

`ifdef GLB_FRAMER_CHECKSUM_EN
            ST_CKSUM: begin
                if (out_fire) begin
                    blk_end = 1'b1;
                end
            end
`endif

            ST_DONE: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                done_d      = 1'b1;
            end

            default: begin
                state_d     = ST_FILL;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase

        // Frame fully transmitted: release the buffer and either accept the
        // next block or stop for good.
        if (blk_end) begin
            cnt_d       = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            if ((NUM_BLOCKS != 0) && (int'(blk_cnt_q) < NUM_BLOCKS)) begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
            if (last_blk) begin
                state_d    = ST_DONE;
                in_ready_d = 1'b0;
                done_d     = 1'b1;
            end else begin
                state_d    = ST_FILL;
                in_ready_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (!rst_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            blk_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            trunc_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef GLB_FRAMER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            blk_cnt_q   <= blk_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            trunc_q     <= trunc_d;
            done_q      <= done_d;
`ifdef GLB_FRAMER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Block buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer is deliberately not reset; a word is only ever read
    // after it has been written in the current block, so stale contents are
    // never observed, and leaving out the reset lets this map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[cnt_q[PTR_W-1:0]] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign trunc     = trunc_q;
    assign done      = done_q;

endmodule

// File: tb/tb_glb_block_framer.sv
// -----------------------------------------------------------------------------
// tb_glb_block_framer
//
// Directed and randomized stimulus for glb_block_framer (DEPTH=4, NUM_BLOCKS=2
// so truncation and done are reachable quickly). A frame-level reference model
// turns every accepted input word into expected output frames; per-cycle checks
// cover header latency, trunc, done, handshake exclusivity and output
// stability under backpressure. GLB_FRAMER_CHECKSUM_EN is honoured here too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_glb_block_framer;

    localparam int DW       = 16;
    localparam int DEPTH_TB = 4;
    localparam int NB       = 2;

`ifdef GLB_FRAMER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          trunc;
    logic          done;

    always #5 clk = ~clk;

    glb_block_framer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH_TB),
        .NUM_BLOCKS (NB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .trunc     (trunc),
        .done      (done)
    );

    typedef struct packed { logic [DW-1:0] data; logic last; } in_word_t;
    typedef struct packed { logic [DW-1:0] data; logic eof;  } exp_word_t;

    in_word_t      in_q[$];
    exp_word_t     exp_q[$];
    logic [DW-1:0] cur_blk[$];
    logic          rdy_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            frames_sent = 0;
    logic          hdr_next = 1'b0;
    logic          trunc_next = 1'b0;
    logic          frame_end_next = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        exp_q.delete();
        cur_blk.delete();
        rdy_q.delete();
        frames_sent    = 0;
        hdr_next       = 1'b0;
        trunc_next     = 1'b0;
        frame_end_next = 1'b0;
        prev_stall     = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic l);
        in_q.push_back('{data: d, last: l});
    endtask

    // Frame rules: a block closes on in_last or at DEPTH words; the frame is
    // the word count, the words, and (checksum build) their 16-bit sum.
    task automatic model_accept(input in_word_t w);
        logic [DW-1:0] sum;
        int            n;
        cur_blk.push_back(w.data);
        if (w.last || (cur_blk.size() == DEPTH_TB)) begin
            n   = cur_blk.size();
            sum = '0;
            exp_q.push_back('{data: DW'(n), eof: 1'b0});
            for (int i = 0; i < n; i++) begin
                sum = sum + cur_blk[i];
                exp_q.push_back('{data: cur_blk[i], eof: (!CK && (i == n - 1))});
            end
            if (CK) exp_q.push_back('{data: sum, eof: 1'b1});
            hdr_next   = 1'b1;
            trunc_next = !w.last;
            cur_blk.delete();
        end
    endtask

    task automatic sample_checks();
        check("trunc", 32'(trunc), 32'(trunc_next));
        check("done", 32'(done), 32'(frames_sent >= NB));
        check("in_out_excl", 32'(in_ready & out_valid), 32'(0));
        if (hdr_next) check("hdr_latency", 32'(out_valid), 32'(1));
        if (frame_end_next) begin
            check("frame_end_out_valid", 32'(out_valid), 32'(0));
            check("frame_end_in_ready", 32'(in_ready), 32'(frames_sent < NB));
        end
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_data", 32'(out_data), 32'(prev_data));
        end
        hdr_next       = 1'b0;
        trunc_next     = 1'b0;
        frame_end_next = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_trunc", 32'(trunc), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        check("post_rst_out_valid", 32'(out_valid), 32'(0));
    endtask

    // mode 0: continuous valid/ready; 1: random gaps and backpressure;
    // 2: out_ready taken from rdy_q (then 1). max_outs < 0 runs until the
    // model is drained, otherwise stops after that many output transfers.
    task automatic run(input int mode, input int max_outs, input int budget);
        int        outs;
        int        cyc;
        bit        fin;
        logic      in_fire;
        logic      out_fire;
        exp_word_t e;
        in_word_t  w;
        outs = 0;
        cyc  = 0;
        fin  = 1'b0;
        while (!fin) begin
            sample_checks();
            if ((max_outs >= 0) && (outs >= max_outs)) begin
                fin = 1'b1;
            end else if ((max_outs < 0) && (in_q.size() == 0) && (exp_q.size() == 0)) begin
                fin = 1'b1;
            end else if (cyc >= budget) begin
                check("timeout_pending_words", 32'(in_q.size() + exp_q.size()), 32'(0));
                fin = 1'b1;
            end else begin
                if ((in_q.size() != 0) && ((mode != 1) || ($urandom_range(0, 3) != 0))) begin
                    in_valid = 1'b1;
                    in_data  = in_q[0].data;
                    in_last  = in_q[0].last;
                end else begin
                    in_valid = 1'b0;
                    in_data  = DW'($urandom);
                    in_last  = 1'($urandom);
                end
                if ((mode == 2) && (rdy_q.size() != 0)) out_ready = rdy_q.pop_front();
                else if (mode == 1)                      out_ready = ($urandom_range(0, 2) != 0);
                else                                     out_ready = 1'b1;

                in_fire  = in_valid & in_ready;
                out_fire = out_valid & out_ready;
                if (out_fire) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", 32'(out_valid), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        outs++;
                        if (e.eof) begin
                            frames_sent++;
                            frame_end_next = 1'b1;
                        end
                    end
                end
                if (in_fire) begin
                    w = in_q.pop_front();
                    model_accept(w);
                end
                prev_stall = out_valid & ~out_ready;
                prev_data  = out_data;
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    int frames;
    int len;

    initial begin
        // Reset state
        do_reset();

        // 3-word block, continuous ready
        push_word(16'h0011, 1'b0);
        push_word(16'h0022, 1'b0);
        push_word(16'h0033, 1'b1);
        run(0, -1, 100);

        // Two blocks reach NUM_BLOCKS; done sticks, input stays blocked
        do_reset();
        push_word(16'hAAAA, 1'b1);
        push_word(16'h0001, 1'b0);
        push_word(16'h0002, 1'b1);
        run(0, -1, 100);
        in_valid  = 1'b1;
        in_data   = 16'h5555;
        in_last   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("done_hold", 32'(done), 32'(1));
            check("done_in_ready", 32'(in_ready), 32'(0));
            check("done_out_valid", 32'(out_valid), 32'(0));
        end

        // Truncation at DEPTH: 6 words 0..5, last on 5
        do_reset();
        for (int i = 0; i < 6; i++) push_word(DW'(i), (i == 5));
        run(0, -1, 100);

        // Backpressure 1,0,0,1 during DRAIN
        do_reset();
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0100 + i), (i == 3));
        for (int i = 0; i < 5; i++) rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b1);
        run(2, -1, 100);

        // Reset mid-DRAIN after one completed block; block count restarts
        do_reset();
        push_word(16'h1234, 1'b1);
        run(0, -1, 100);
        push_word(16'h0101, 1'b0);
        push_word(16'h0202, 1'b0);
        push_word(16'h0303, 1'b1);
        run(0, 2, 100);
        check("mid_drain_valid", 32'(out_valid), 32'(1));
        do_reset();
        push_word(16'h0F0F, 1'b1);
        run(0, -1, 100);
        push_word(16'h0A0A, 1'b0);
        push_word(16'h0B0B, 1'b1);
        run(0, -1, 100);

        // Wrap-around data (checksum frame when enabled)
        do_reset();
        push_word(16'hFFFF, 1'b0);
        push_word(16'h0002, 1'b1);
        run(0, -1, 100);

        // Randomized blocks, gaps and backpressure
        for (int r = 0; r < 10; r++) begin
            do_reset();
            frames = 0;
            while (frames < NB) begin
                if ((NB - frames) >= 2) len = $urandom_range(1, 6);
                else                    len = $urandom_range(1, DEPTH_TB);
                for (int i = 0; i < len; i++) push_word(DW'($urandom), (i == len - 1));
                frames = frames + ((len > DEPTH_TB) ? 2 : 1);
            end
            run(1, -1, 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
